// File: rtl/nla_frame_sequencer.sv
// Frame sequencer for the FP32 BRAM FIFO in front of the nonlinear engine: START_TOKEN-gated FILL, then DRAIN
// through a 2-entry buffer. Optional NLA_SEQ_STATS_EN adds a wrapping frame_cnt_o counter.
module nla_frame_sequencer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_LINES  = 12,
    parameter int                    FRAME_LEN   = 16,
    parameter logic [DATA_WIDTH-1:0] START_TOKEN = 32'h7F90_0000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_rd_en_o,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  frame_err_o
`ifdef NLA_SEQ_STATS_EN
    ,
    output logic [15:0]           frame_cnt_o
`endif
);

    // A frame can never hold more words than the FIFO has entries.
    localparam int DEPTH = 1 << ADDR_LINES;
    localparam int FLEN  = (FRAME_LEN < DEPTH) ? FRAME_LEN : DEPTH;
    localparam int CW    = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST   = CW'(FLEN - 1);
    localparam logic [CW-1:0] FLEN_C = CW'(FLEN);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_wcnt;
    logic [CW-1:0]         r_rcnt;
    logic [CW-1:0]         r_ocnt;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [1:0]            r_bcnt;
    logic                  r_pend;
    logic                  r_err;
`ifdef NLA_SEQ_STATS_EN
    logic [15:0]           r_frame_cnt;
`endif

    logic       w_is_token;
    logic       w_ready;
    logic       w_accept;
    logic       w_wr;
    logic       w_tok_err;
    logic       w_out_valid;
    logic       w_pop;
    logic       w_last;
    logic [2:0] w_occ;
    logic       w_rd;

    assign w_is_token  = (in_data_i == START_TOKEN);
    assign w_ready     = rstn_i & ((r_state == S_IDLE) | ((r_state == S_FILL) & ~fifo_full_i));
    assign w_accept    = in_valid_i & w_ready;
    assign w_wr        = w_accept & (r_state == S_FILL) & ~w_is_token;
    assign w_tok_err   = w_accept & (r_state == S_FILL) & w_is_token;
    assign w_out_valid = rstn_i & (r_bcnt != 2'd0);
    assign w_pop       = w_out_valid & out_ready_i;
    assign w_last      = w_out_valid & (r_ocnt == LAST);

    // Occupancy after this cycle's pop, counting the read already in flight; a full
    // buffer blocks issue even while it drains so reads restart one cycle later.
    assign w_occ = {1'b0, r_bcnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_rd  = rstn_i & (r_state == S_DRAIN) & ~fifo_empty_i & (r_rcnt < FLEN_C)
                 & (r_bcnt != 2'd2) & (w_occ < 3'd2);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_ocnt  <= '0;
            r_bcnt  <= 2'd0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
`ifdef NLA_SEQ_STATS_EN
            r_frame_cnt <= 16'd0;
`endif
        end else begin
            r_pend <= w_rd;
            r_err  <= w_tok_err;
            case ({w_pop, r_pend})
                2'b01:   r_bcnt <= r_bcnt + 2'd1;
                2'b10:   r_bcnt <= r_bcnt - 2'd1;
                default: ;
            endcase
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_token) begin
                        r_state <= S_FILL;
                        r_wcnt  <= '0;
                    end
                end
                S_FILL: begin
                    if (w_wr) begin
                        r_wcnt <= r_wcnt + ONE;
                        if (r_wcnt == LAST) begin
                            r_state <= S_DRAIN;
                            r_rcnt  <= '0;
                            r_ocnt  <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_rd) begin
                        r_rcnt <= r_rcnt + ONE;
                    end
                    if (w_pop) begin
                        r_ocnt <= r_ocnt + ONE;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef NLA_SEQ_STATS_EN
            if (w_pop && w_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
`endif
        end
    end

    // Buffer data is qualified by r_bcnt, so it needs no reset.
    always_ff @(posedge clk_i) begin
        case ({w_pop, r_pend})
            2'b01: begin
                if (r_bcnt == 2'd0) r_buf0 <= fifo_data_i;
                else                r_buf1 <= fifo_data_i;
            end
            2'b10: r_buf0 <= r_buf1;
            2'b11: begin
                if (r_bcnt == 2'd1) begin
                    r_buf0 <= fifo_data_i;
                end else begin
                    r_buf0 <= r_buf1;
                    r_buf1 <= fifo_data_i;
                end
            end
            default: ;
        endcase
    end

    assign in_ready_o   = w_ready;
    assign fifo_wr_en_o = w_wr;
    assign fifo_data_o  = in_data_i;
    assign fifo_rd_en_o = w_rd;
    assign out_valid_o  = w_out_valid;
    assign out_data_o   = w_out_valid ? r_buf0 : '0;
    assign out_last_o   = w_last;
    assign busy_o       = rstn_i & (r_state != S_IDLE);
    assign frame_err_o  = rstn_i & r_err;
`ifdef NLA_SEQ_STATS_EN
    assign frame_cnt_o  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_nla_frame_sequencer.sv
// Directed bench for nla_frame_sequencer (FRAME_LEN = 4) with a queue-based FIFO stand-in.
module tb_nla_frame_sequencer;
    localparam int          FL  = 4;
    localparam logic [31:0] TOK = 32'h7F90_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rdata = 32'h0;
    logic        out_ready = 1'b1;
    wire         in_ready;
    wire         fifo_wr_en;
    wire  [31:0] fifo_wdata;
    wire         fifo_rd_en;
    wire         out_valid;
    wire  [31:0] out_data;
    wire         out_last;
    wire         busy;
    wire         frame_err;
`ifdef NLA_SEQ_STATS_EN
    wire  [15:0] frame_cnt;
`endif

    nla_frame_sequencer #(.DATA_WIDTH(32), .ADDR_LINES(12), .FRAME_LEN(FL), .START_TOKEN(TOK)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .fifo_wr_en_o(fifo_wr_en), .fifo_data_o(fifo_wdata), .fifo_full_i(fifo_full),
        .fifo_rd_en_o(fifo_rd_en), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_rdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .busy_o(busy), .frame_err_o(frame_err)
`ifdef NLA_SEQ_STATS_EN
        , .frame_cnt_o(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          hs_idx = 0;
    int          m_bcnt = 0;
    logic        m_pend = 1'b0;
    logic        m_hold = 1'b0;
    logic [31:0] m_hold_data = 32'h0;
    logic [31:0] e_word;
    logic [31:0] exp_q[$];
    logic [31:0] fq[$];
    logic        bp_en = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;
    int          bp_idx = 0;
    int          w0 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // FIFO stand-in, cleared by the shared reset net.
    always @(posedge clk) begin
        if (!rstn) begin
            fq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_wr_en) fq.push_back(fifo_wdata);
            if (fifo_rd_en && fq.size() > 0) fifo_rdata <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1 out_ready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end
    end

    // Per-cycle scoreboard: ordering, last flag, exclusivity, buffer occupancy, hold.
    always @(negedge clk) begin
        if (!rstn) begin
            m_bcnt = 0;
            m_pend = 1'b0;
            m_hold = 1'b0;
            hs_idx = 0;
        end else begin
            check_eq("wr_rd_excl", 32'(fifo_wr_en & fifo_rd_en), 32'd0);
            check_eq("buf_valid", 32'(out_valid), 32'(m_bcnt != 0));
            if (m_bcnt == 2) check_eq("rd_when_buf2", 32'(fifo_rd_en), 32'd0);
            if (fifo_wr_en) begin
                check_eq("wr_not_token", 32'(fifo_wdata == TOK), 32'd0);
                wr_cnt++;
            end
            if (m_hold) check_eq("hold_data", out_data, m_hold_data);
            if (out_valid) check_eq("out_last", 32'(out_last), 32'(hs_idx == FL - 1));
            else           check_eq("last_idle", 32'(out_last), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_extra", 32'd1, 32'd0);
                end else begin
                    e_word = exp_q.pop_front();
                    check_eq("out_data", out_data, e_word);
                end
                hs_idx = (hs_idx == FL - 1) ? 0 : hs_idx + 1;
            end
            m_hold      = out_valid & ~out_ready;
            m_hold_data = out_data;
            m_bcnt      = m_bcnt - ((out_valid && out_ready) ? 1 : 0) + (m_pend ? 1 : 0);
            m_pend      = fifo_rd_en;
        end
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", 32'(n < 200), 32'd1);
        check_eq("exp_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
        send(TOK); send(a); send(b); send(c); send(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Basic frame with leading junk, then exact cycle timing of the drain.
        w0 = wr_cnt;
        send(32'h3F80_0000);
        send(32'h4000_0000);
        check_eq("idle_drop", 32'(wr_cnt - w0), 32'd0);
        exp_q.push_back(32'h3F80_0000); exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4040_0000); exp_q.push_back(32'h4080_0000);
        send(TOK);
        check_eq("fill_busy", 32'(busy), 32'd1);
        send(32'h3F80_0000); send(32'h4000_0000); send(32'h4040_0000); send(32'h4080_0000);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("first_rd_t1", 32'(fifo_rd_en), 32'd1);
            if (k == 5) check_eq("rd_done_t5", 32'(fifo_rd_en), 32'd0);
            check_eq("lat_valid", 32'(out_valid), 32'(k >= 3 && k <= 6));
            check_eq("lat_last", 32'(out_last), 32'(k == 6));
            check_eq("lat_busy", 32'(busy), 32'(k <= 6));
        end
        check_eq("idle_ready_t7", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();
        check_eq("basic_writes", 32'(wr_cnt - w0), 32'd4);

        // Token as second frame word.
        w0 = wr_cnt;
        exp_q.push_back(32'h1111_1111); exp_q.push_back(32'h2222_2222);
        exp_q.push_back(32'h3333_3333); exp_q.push_back(32'h4444_4444);
        send(TOK);
        send(32'h1111_1111);
        send(TOK);
        @(negedge clk);
        check_eq("tok_err_pulse", 32'(frame_err), 32'd1);
        check_eq("tok_still_fill", 32'(busy & in_ready), 32'd1);
        @(negedge clk);
        check_eq("tok_err_clear", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        check_eq("tok_writes_mid", 32'(wr_cnt - w0), 32'd1);
        send(32'h2222_2222); send(32'h3333_3333); send(32'h4444_4444);
        wait_idle();
        check_eq("tok_writes", 32'(wr_cnt - w0), 32'd4);

        // FIFO full stalls the held word for three cycles.
        w0 = wr_cnt;
        exp_q.push_back(32'hA000_0001); exp_q.push_back(32'hA000_0002);
        exp_q.push_back(32'hA000_0003); exp_q.push_back(32'hA000_0004);
        send(TOK);
        send(32'hA000_0001);
        fifo_full = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA000_0002;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("full_in_ready", 32'(in_ready), 32'd0);
            check_eq("full_wr_en", 32'(fifo_wr_en), 32'd0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check_eq("release_wr_en", 32'(fifo_wr_en), 32'd1);
        check_eq("release_data", fifo_wdata, 32'hA000_0002);
        @(posedge clk);
        #1 in_valid = 1'b0;
        send(32'hA000_0003);
        send(32'hA000_0004);
        wait_idle();
        check_eq("full_writes", 32'(wr_cnt - w0), 32'd4);

        // Engine stalled: buffer fills to two, reads stop, head word holds.
        out_ready = 1'b0;
        frame4(32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_eq("stall_rd", 32'(fifo_rd_en), 32'd0);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_head", out_data, 32'h5000_0001);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // Repeating 1,0,0,1 backpressure.
        bp_idx = 0;
        bp_en  = 1'b1;
        frame4(32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004);
        wait_idle();
        bp_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        // One-cycle reset mid-DRAIN.
        out_ready = 1'b0;
        frame4(32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);
        check_eq("post_rst_ready", 32'(in_ready), 32'd1);
`ifdef NLA_SEQ_STATS_EN
        check_eq("stats_reset", 32'(frame_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Three frames after reset.
        for (int f = 0; f < 3; f++) begin
            frame4(32'h0000_0100 + 32'(f * 16), 32'h0000_0101 + 32'(f * 16),
                   32'h0000_0102 + 32'(f * 16), 32'h0000_0103 + 32'(f * 16));
            wait_idle();
        end
`ifdef NLA_SEQ_STATS_EN
        check_eq("stats_three", 32'(frame_cnt), 32'd3);
`endif
        check_eq("frame_aligned", 32'(hs_idx), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
